// File: rtl/hash_row_match_serializer.sv
// Row match serializer: filters the hash candidate lanes of each accepted row and
// emits one match request per cycle, lowest lane first, plus a marker beat for empty delim rows.
module hash_row_match_serializer #(
  parameter int HASH_ISSUE_WIDTH     = 32,
  parameter int ADDR_WIDTH           = 32,
  parameter int META_MATCH_LEN_WIDTH = 5,
  parameter int LANE_IDX_WIDTH       = 5
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [META_MATCH_LEN_WIDTH-1:0]                cfg_min_match_len,
  input  logic                                           input_valid,
  input  logic [ADDR_WIDTH-1:0]                          input_head_addr,
  input  logic [HASH_ISSUE_WIDTH-1:0]                    input_history_valid,
  input  logic [HASH_ISSUE_WIDTH*ADDR_WIDTH-1:0]         input_history_addr,
  input  logic [HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0] input_meta_match_len,
  input  logic [HASH_ISSUE_WIDTH-1:0]                    input_meta_match_can_ext,
  input  logic                                           input_delim,
  output logic                                           input_ready,
  output logic                                           output_valid,
  output logic                                           output_match_valid,
  output logic [LANE_IDX_WIDTH-1:0]                      output_lane,
  output logic [ADDR_WIDTH-1:0]                          output_head_addr,
  output logic [ADDR_WIDTH-1:0]                          output_history_addr,
  output logic [META_MATCH_LEN_WIDTH-1:0]                output_meta_match_len,
  output logic                                           output_meta_match_can_ext,
  output logic                                           output_last,
  output logic                                           output_delim,
  input  logic                                           output_ready,
  output logic [31:0]                                    stat_req_count
);

  localparam int W  = HASH_ISSUE_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int LW = META_MATCH_LEN_WIDTH;
  localparam int IW = LANE_IDX_WIDTH;

  logic            busy;
  logic [W-1:0]    pending;
  logic [AW-1:0]   row_head;
  logic [W*AW-1:0] row_addr;
  logic [W*LW-1:0] row_len;
  logic [W-1:0]    row_ext;
  logic            row_delim;

  logic            fire;
  logic            accept;
  logic [W-1:0]    qual;
  logic [W-1:0]    sel_mask;
  logic [W-1:0]    rem_mask;
  logic [IW-1:0]   sel_lane;

  logic [AW-1:0]   src_head;
  logic [W*AW-1:0] src_addr;
  logic [W*LW-1:0] src_len;
  logic [W-1:0]    src_ext;
  logic            src_delim;

  logic [AW-1:0]   beat_head;
  logic [AW-1:0]   beat_addr;
  logic [LW-1:0]   beat_len;
  logic            beat_ext;
  logic            beat_last;

  function automatic logic [IW-1:0] lowest_lane(input logic [W-1:0] m);
    lowest_lane = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (m[i]) lowest_lane = IW'(i);
    end
  endfunction

  assign fire        = output_valid & output_ready;
  assign input_ready = rst_n & (~busy | (fire & output_last));
  assign accept      = input_valid & input_ready;

  always_comb begin
    qual = '0;
    for (int i = 0; i < W; i++) begin
      qual[i] = input_history_valid[i] & (input_meta_match_len[i*LW +: LW] >= cfg_min_match_len);
    end
  end

  // A newly accepted row presents its first lane straight from the inputs; later
  // lanes come from the captured row registers.
  always_comb begin
    sel_mask  = accept ? qual : pending;
    src_head  = accept ? input_head_addr : row_head;
    src_addr  = accept ? input_history_addr : row_addr;
    src_len   = accept ? input_meta_match_len : row_len;
    src_ext   = accept ? input_meta_match_can_ext : row_ext;
    src_delim = accept ? input_delim : row_delim;
    sel_lane  = lowest_lane(sel_mask);
    rem_mask  = sel_mask & ~(W'(1) << sel_lane);
    beat_head = src_head + AW'(sel_lane);
    beat_addr = src_addr[int'(sel_lane)*AW +: AW];
    beat_len  = src_len[int'(sel_lane)*LW +: LW];
    beat_ext  = src_ext[sel_lane];
    beat_last = (rem_mask == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy                      <= 1'b0;
      pending                   <= '0;
      row_head                  <= '0;
      row_addr                  <= '0;
      row_len                   <= '0;
      row_ext                   <= '0;
      row_delim                 <= 1'b0;
      output_valid              <= 1'b0;
      output_match_valid        <= 1'b0;
      output_lane               <= '0;
      output_head_addr          <= '0;
      output_history_addr       <= '0;
      output_meta_match_len     <= '0;
      output_meta_match_can_ext <= 1'b0;
      output_last               <= 1'b0;
      output_delim              <= 1'b0;
      stat_req_count            <= '0;
    end else begin
      if (fire && output_match_valid) stat_req_count <= stat_req_count + 32'd1;

      if (accept) begin
        row_head  <= input_head_addr;
        row_addr  <= input_history_addr;
        row_len   <= input_meta_match_len;
        row_ext   <= input_meta_match_can_ext;
        row_delim <= input_delim;
      end

      if (accept && (qual != '0)) begin
        busy                      <= 1'b1;
        pending                   <= rem_mask;
        output_valid              <= 1'b1;
        output_match_valid        <= 1'b1;
        output_lane               <= sel_lane;
        output_head_addr          <= beat_head;
        output_history_addr       <= beat_addr;
        output_meta_match_len     <= beat_len;
        output_meta_match_can_ext <= beat_ext;
        output_last               <= beat_last;
        output_delim              <= src_delim & beat_last;
      end else if (accept && input_delim) begin
        busy                      <= 1'b1;
        pending                   <= '0;
        output_valid              <= 1'b1;
        output_match_valid        <= 1'b0;
        output_lane               <= '0;
        output_head_addr          <= input_head_addr;
        output_history_addr       <= '0;
        output_meta_match_len     <= '0;
        output_meta_match_can_ext <= 1'b0;
        output_last               <= 1'b1;
        output_delim              <= 1'b1;
      end else if (accept || (fire && output_last)) begin
        // Empty non-delim row, or the final beat left with nothing behind it.
        busy         <= 1'b0;
        pending      <= '0;
        output_valid <= 1'b0;
      end else if (fire) begin
        pending                   <= rem_mask;
        output_match_valid        <= 1'b1;
        output_lane               <= sel_lane;
        output_head_addr          <= beat_head;
        output_history_addr       <= beat_addr;
        output_meta_match_len     <= beat_len;
        output_meta_match_can_ext <= beat_ext;
        output_last               <= beat_last;
        output_delim              <= src_delim & beat_last;
      end
    end
  end

endmodule

// File: tb/tb_hash_row_match_serializer.sv
// Bench for hash_row_match_serializer: table vectors, hand sequences for stall,
// back-to-back and mid-row reset, then random rows against a scoreboard model.
module tb_hash_row_match_serializer;

  localparam int W  = 32;
  localparam int AW = 32;
  localparam int LW = 5;
  localparam int IW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [LW-1:0]     cfg_min_match_len;
  logic              input_valid;
  logic [AW-1:0]     input_head_addr;
  logic [W-1:0]      input_history_valid;
  logic [W*AW-1:0]   input_history_addr;
  logic [W*LW-1:0]   input_meta_match_len;
  logic [W-1:0]      input_meta_match_can_ext;
  logic              input_delim;
  logic              input_ready;
  logic              output_valid;
  logic              output_match_valid;
  logic [IW-1:0]     output_lane;
  logic [AW-1:0]     output_head_addr;
  logic [AW-1:0]     output_history_addr;
  logic [LW-1:0]     output_meta_match_len;
  logic              output_meta_match_can_ext;
  logic              output_last;
  logic              output_delim;
  logic              output_ready;
  logic [31:0]       stat_req_count;

  hash_row_match_serializer #(
    .HASH_ISSUE_WIDTH(W), .ADDR_WIDTH(AW), .META_MATCH_LEN_WIDTH(LW), .LANE_IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_min_match_len(cfg_min_match_len),
    .input_valid(input_valid), .input_head_addr(input_head_addr),
    .input_history_valid(input_history_valid), .input_history_addr(input_history_addr),
    .input_meta_match_len(input_meta_match_len), .input_meta_match_can_ext(input_meta_match_can_ext),
    .input_delim(input_delim), .input_ready(input_ready),
    .output_valid(output_valid), .output_match_valid(output_match_valid),
    .output_lane(output_lane), .output_head_addr(output_head_addr),
    .output_history_addr(output_history_addr), .output_meta_match_len(output_meta_match_len),
    .output_meta_match_can_ext(output_meta_match_can_ext), .output_last(output_last),
    .output_delim(output_delim), .output_ready(output_ready), .stat_req_count(stat_req_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          mv;
    logic [IW-1:0] lane;
    logic [AW-1:0] head;
    logic [AW-1:0] hist;
    logic [LW-1:0] len;
    logic          ext;
    logic          last;
    logic          delim;
  } beat_t;

  typedef struct {
    logic [31:0] head;
    logic [31:0] hv;
    logic [4:0]  len;
    bit          lane2_short;
    bit          delim;
    logic [4:0]  cfg;
    logic [31:0] exp_mask;
    int          exp_beats;
  } vec_t;

  beat_t       exp_q[$];
  int          fire_cyc[$];
  logic        ir_at_last[$];
  int          checks = 0;
  int          failures = 0;
  int          nbeats = 0;
  int          stat_exp = 0;
  int          cyc = 0;
  int          rmode = 0;
  bit          rec = 0;
  bit          held = 0;
  beat_t       held_beat;

  logic [31:0] r_hist [W];
  logic [4:0]  r_len  [W];
  logic [31:0] cur_head, cur_hv, cur_ext;
  logic        cur_delim;
  logic [4:0]  cur_cfg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic stage_row();
    input_head_addr          = cur_head;
    input_history_valid      = cur_hv;
    input_meta_match_can_ext = cur_ext;
    input_delim              = cur_delim;
    cfg_min_match_len        = cur_cfg;
    for (int i = 0; i < W; i++) begin
      input_history_addr[i*AW +: AW]   = r_hist[i];
      input_meta_match_len[i*LW +: LW] = r_len[i];
    end
  endtask

  // Expected beats for a row whose qualifying lanes are 'mask'.
  task automatic push_lanes(input logic [31:0] mask);
    int    lanes[$];
    beat_t b;
    for (int i = 0; i < W; i++) if (mask[i]) lanes.push_back(i);
    if (lanes.size() == 0) begin
      if (cur_delim) begin
        b = '0;
        b.head = cur_head; b.last = 1'b1; b.delim = 1'b1;
        exp_q.push_back(b);
      end
    end else begin
      for (int k = 0; k < lanes.size(); k++) begin
        b.mv    = 1'b1;
        b.lane  = IW'(lanes[k]);
        b.head  = cur_head + 32'(lanes[k]);
        b.hist  = r_hist[lanes[k]];
        b.len   = r_len[lanes[k]];
        b.ext   = cur_ext[lanes[k]];
        b.last  = (k == lanes.size() - 1);
        b.delim = cur_delim && (k == lanes.size() - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic model_push();
    logic [31:0] m;
    for (int i = 0; i < W; i++) m[i] = cur_hv[i] && (r_len[i] >= cur_cfg);
    push_lanes(m);
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the row.
  task automatic send_row(input bit use_model);
    int c;
    stage_row();
    input_valid = 1'b1;
    c = 0;
    forever begin
      @(negedge clk);
      if (input_ready) break;
      c++;
      if (c > 2000) begin
        checks++; failures++;
        $display("FAIL accept_timeout actual=no_accept required=accept");
        break;
      end
      @(posedge clk); #1;
    end
    if (use_model) model_push();
    @(posedge clk); #1;
    input_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !output_valid) return;
    end
    checks++; failures++;
    $display("FAIL drain_timeout actual=pending=%0d required=0", exp_q.size());
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: output_ready = 1'b1;
      1: output_ready = 1'($urandom_range(0, 1));
      default: output_ready = ~output_ready;
    endcase
  end

  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    cyc++;
    got.mv = output_match_valid; got.lane = output_lane; got.head = output_head_addr;
    got.hist = output_history_addr; got.len = output_meta_match_len;
    got.ext = output_meta_match_can_ext; got.last = output_last; got.delim = output_delim;
    if (!rst_n) begin
      exp_q.delete();
      stat_exp = 0;
      held = 0;
    end else begin
      if (held) begin
        checks++;
        if (!output_valid || got != held_beat) begin
          failures++;
          $display("FAIL stall_hold actual=v%0d %h required=v1 %h", output_valid, got, held_beat);
        end
      end
      if (output_valid && output_ready) begin
        checks++;
        nbeats++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected actual=%h required=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got != e) begin
            failures++;
            $display("FAIL beat actual=%h required=%h", got, e);
          end
          if (e.mv) stat_exp++;
        end
        if (rec) begin
          fire_cyc.push_back(cyc);
          if (output_last) ir_at_last.push_back(input_ready);
        end
      end
      held = output_valid && !output_ready;
      held_beat = got;
    end
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h100, 32'h25, 5'd8, 0, 0, 5'd3, 32'h25, 3};
    vecs[1] = '{32'h100, 32'h25, 5'd8, 1, 0, 5'd3, 32'h21, 2};
    vecs[2] = '{32'h200, 32'h0, 5'd8, 0, 1, 5'd3, 32'h0, 1};
    vecs[3] = '{32'h200, 32'h0, 5'd8, 0, 0, 5'd3, 32'h0, 0};
    vecs[4] = '{32'hFFFF_FFFE, 32'h8000_0003, 5'd0, 0, 1, 5'd0, 32'h8000_0003, 3};
    vecs[5] = '{32'h300, 32'hF0, 5'd30, 0, 1, 5'd31, 32'h0, 1};
    vecs[6] = '{32'h400, 32'hF0, 5'd31, 0, 0, 5'd31, 32'hF0, 4};
    vecs[7] = '{32'h500, 32'hFFFF_FFFF, 5'd1, 0, 1, 5'd1, 32'hFFFF_FFFF, 32};

    rst_n = 1'b0; input_valid = 1'b0; output_ready = 1'b1;
    cur_head = '0; cur_hv = '0; cur_ext = '0; cur_delim = 1'b0; cur_cfg = '0;
    for (int i = 0; i < W; i++) begin r_hist[i] = '0; r_len[i] = '0; end
    stage_row();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_output_valid", 64'(output_valid), 64'd0);
    chk("rst_input_ready", 64'(input_ready), 64'd0);
    chk("rst_stat", 64'(stat_req_count), 64'd0);
    chk("rst_head_addr", 64'(output_head_addr), 64'd0);
    align();
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      align();
      cur_head = vecs[v].head; cur_hv = vecs[v].hv; cur_delim = vecs[v].delim;
      cur_cfg = vecs[v].cfg; cur_ext = 32'h5555_5555;
      for (int i = 0; i < W; i++) begin
        r_hist[i] = 32'h4000 + 32'(i * 8);
        r_len[i]  = (vecs[v].lane2_short && i == 2) ? 5'd2 : vecs[v].len;
      end
      nbeats = 0;
      push_lanes(vecs[v].exp_mask);
      send_row(0);
      drain();
      chk($sformatf("beats_v%0d", v), 64'(nbeats), 64'(vecs[v].exp_beats));
      if (v == 0) chk("stat_after_first_row", 64'(stat_req_count), 64'd3);
      if (vecs[v].exp_beats == 0) begin
        @(negedge clk);
        chk("empty_row_ready", 64'(input_ready), 64'd1);
        chk("empty_row_no_beat", 64'(output_valid), 64'd0);
      end
      chk($sformatf("stat_v%0d", v), 64'(stat_req_count), 64'(stat_exp));
    end

    // Stalled delivery with output_ready alternating.
    align();
    rmode = 2;
    cur_head = 32'h800; cur_hv = 32'h8421; cur_delim = 1'b1; cur_cfg = 5'd3; cur_ext = 32'h0000_0400;
    for (int i = 0; i < W; i++) begin r_hist[i] = 32'hB000 + 32'(i); r_len[i] = 5'd8; end
    nbeats = 0;
    send_row(1);
    drain();
    chk("toggle_beats", 64'(nbeats), 64'd4);

    // Back-to-back rows, zero bubble.
    align();
    rmode = 0;
    fire_cyc.delete(); ir_at_last.delete(); rec = 1;
    cur_head = 32'h900; cur_hv = 32'h3; cur_delim = 1'b0; cur_cfg = 5'd1;
    send_row(1);
    cur_head = 32'hA00; cur_hv = 32'h18; cur_delim = 1'b1;
    send_row(1);
    drain();
    rec = 0;
    chk("b2b_fires", 64'(fire_cyc.size()), 64'd4);
    if (fire_cyc.size() == 4) chk("b2b_gap", 64'(fire_cyc[3] - fire_cyc[0]), 64'd3);
    if (ir_at_last.size() > 0) chk("b2b_ready_at_last", 64'(ir_at_last[0]), 64'd1);

    // Reset after the first of four beats has fired.
    align();
    cur_head = 32'hC00; cur_hv = 32'hF; cur_delim = 1'b0; cur_cfg = 5'd1;
    send_row(1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_output_valid", 64'(output_valid), 64'd0);
    chk("midrst_stat", 64'(stat_req_count), 64'd0);
    chk("midrst_input_ready", 64'(input_ready), 64'd0);
    align();
    rst_n = 1'b1;
    align();
    cur_head = 32'hD00; cur_hv = 32'h30; cur_delim = 1'b1;
    nbeats = 0;
    send_row(1);
    drain();
    chk("post_rst_beats", 64'(nbeats), 64'd2);
    chk("post_rst_stat", 64'(stat_req_count), 64'd2);

    // Random rows, random backpressure, no gaps between submissions.
    align();
    rmode = 1;
    for (int n = 0; n < 40; n++) begin
      cur_head  = $urandom;
      cur_hv    = (n % 5 == 0) ? 32'h0 : ($urandom & $urandom);
      cur_ext   = $urandom;
      cur_delim = 1'($urandom_range(0, 1));
      cur_cfg   = 5'($urandom_range(0, 12));
      for (int i = 0; i < W; i++) begin
        r_hist[i] = $urandom;
        r_len[i]  = 5'($urandom_range(0, 31));
      end
      send_row(1);
    end
    drain();
    chk("rand_stat", 64'(stat_req_count), 64'(stat_exp));
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hash_row_match_serializer.md
Name: hash_row_match_serializer

Overview:
- Sits directly downstream of the post-hash PE scheduler and consumes its synchronized per-row output: one head address, HASH_ISSUE_WIDTH lanes of history candidates, and a delim flag.
- Filters each lane: a lane qualifies when its history is valid and its meta match length is at least the configured minimum.
- Serializes qualifying lanes, lowest lane index first, into one match request per cycle for the downstream match PEs.
- Emits a single marker beat for delim rows that have no qualifying lanes.

Parameters:
HASH_ISSUE_WIDTH, 32, lanes per row (power of two)
ADDR_WIDTH, 32, address width
META_MATCH_LEN_WIDTH, 5, meta match length width
LANE_IDX_WIDTH, 5, log2(HASH_ISSUE_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cfg_min_match_len  in  META_MATCH_LEN_WIDTH  lane qualifies iff history_valid & meta_match_len >= this value; sampled at row accept
input_valid  in  1  row valid
input_head_addr  in  ADDR_WIDTH  address of lane 0
input_history_valid  in  HASH_ISSUE_WIDTH  per-lane candidate valid
input_history_addr  in  HASH_ISSUE_WIDTH*ADDR_WIDTH  per-lane candidate address
input_meta_match_len  in  HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH  per-lane meta length
input_meta_match_can_ext  in  HASH_ISSUE_WIDTH  per-lane extension flag
input_delim  in  1  row ends a block
input_ready  out  1  row accept
output_valid  out  1  beat valid
output_match_valid  out  1  1 = real request; 0 = delim-only marker
output_lane  out  LANE_IDX_WIDTH  lane index of request
output_head_addr  out  ADDR_WIDTH  input_head_addr + lane, modulo 2^ADDR_WIDTH
output_history_addr  out  ADDR_WIDTH  candidate address
output_meta_match_len  out  META_MATCH_LEN_WIDTH  lane meta length
output_meta_match_can_ext  out  1  lane extension flag
output_last  out  1  final beat of row
output_delim  out  1  row delim; asserted only when output_last=1
output_ready  in  1  downstream accept
stat_req_count  out  32  count of fired beats with output_match_valid=1; wraps

Behaviour:
- State: busy flag; pending mask (HASH_ISSUE_WIDTH); row registers holding head_addr, addrs, lens, can_ext, delim; output registers.
- Row accept: input_valid & input_ready. Qualifying mask computed combinationally with the sampled cfg_min_match_len.
- input_ready = rst_n & (~busy | (output_valid & output_ready & output_last)). This allows back-to-back rows with zero bubble.
- Row with zero qualifying lanes and delim=0: consumed in one cycle. No beat, busy unchanged.
- Row with zero qualifying lanes and delim=1: one beat with output_match_valid=0, output_last=1, output_delim=1, output_lane=0, output_head_addr=head_addr, other data fields 0.
- Otherwise busy=1 and pending = qualifying mask.
- First beat is presented the cycle after accept (latency 1, registered outputs).
- Each beat presents the lowest set pending lane.
- output_last=1 iff no other pending bit remains after this lane.
- Outputs hold stable while output_valid & ~output_ready.
- On fire: clear that pending bit. The next lane is presented the following cycle (1 beat/cycle at full throughput).
- On the fire of the last beat: busy=0, or reload immediately if a new row is accepted in the same cycle.
- Throughput: N qualifying lanes = N cycles; one beat per cycle.
- stat_req_count increments on output_valid & output_ready & output_match_valid; 0xFFFFFFFF wraps to 0.
- cfg_min_match_len=0: every history_valid lane qualifies.
- Reset (at any time, including mid-row): output_valid=0, busy=0, pending=0, all output data fields 0, stat_req_count=0, input_ready=0 while rst_n=0. No partial row survives reset.
- Overflow: head_addr+lane wraps modulo 2^ADDR_WIDTH, with no carry out.

Test Plan:
- Row head=0x100, history_valid=0x0000_0025, lens all 8, cfg_min=3 -> 3 beats, lanes 0,2,5, head_addr 0x100/0x102/0x105, last only on lane 5; stat_req_count=3.
- Same row with lane 2 len=2, cfg_min=3 -> beats for lanes 0 and 5 only; lane 5 last.
- Row history_valid=0 with delim=1 -> single beat: match_valid=0, last=1, delim=1. Same row with delim=0 -> no beat, input_ready stays 1.
- Two rows back-to-back (2 lanes each), output_ready=1 -> 4 consecutive beats with no bubble; input_ready=1 in the cycle the last beat of row 1 fires.
- output_ready toggling 1010 during a 4-lane row -> beats held stable while stalled; lane order preserved; no duplicates or drops.
- rst_n low after 1 of 4 beats has fired -> output_valid=0 the next cycle, stat_req_count=0; a new row after reset emits only its own lanes.
